// File: rtl/nx_token_scheduler_pkg.sv
// nx_token_scheduler_pkg: shared state encoding and defaults for the token scheduler
package nx_token_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    HOLD,
    DONE
  } token_sched_state_t;

  localparam int TOKEN_HOLD_LIMIT = 64;

endpackage

// File: rtl/nx_token_seek.sv
// nx_token_seek: find the lowest set mask bit at or above a start index
module nx_token_seek #(
  parameter int NODES = 8
) (
  input  logic [NODES-1:0]         mask,
  input  logic [$clog2(NODES)-1:0] start,
  output logic [$clog2(NODES)-1:0] idx,
  output logic                     found
);

  localparam int IW = $clog2(NODES);

  // scan downwards so the last hit written is the lowest qualifying bit
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (mask[i] && i >= int'(start)) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_token_scheduler.sv
// nx_token_scheduler: passes one outbound channel token round-robin across a node column per step
module nx_token_scheduler
  import nx_token_scheduler_pkg::*;
#(
  parameter int NODES       = 8,
  parameter int HOLD_LIMIT  = TOKEN_HOLD_LIMIT,
  parameter int ROUND_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trigger_i,
  input  logic [NODES-1:0]         active_mask_i,
  input  logic                     clear_i,
  output logic [NODES-1:0]         token_grant_o,
  input  logic [NODES-1:0]         token_release_i,
  output logic                     busy_o,
  output logic [$clog2(NODES)-1:0] holder_o,
  output logic                     round_done_o,
  output logic [ROUND_WIDTH-1:0]   round_count_o,
  output logic                     stall_o,
  output logic                     overrun_o,
  output logic                     spurious_o
);

  localparam int IW = $clog2(NODES);
  localparam int CW = $clog2(HOLD_LIMIT + 1);

  token_sched_state_t state, next;
  logic [NODES-1:0]       mask_q;
  logic [IW-1:0]          ptr_q, holder_q, seek_idx;
  logic [CW-1:0]          hold_q;
  logic [ROUND_WIDTH-1:0] count_q;
  logic                   seek_found, rel_ok, last;
  logic                   stall_q, overrun_q, spurious_q;
  logic                   stall_set, overrun_set, spurious_set;

  nx_token_seek #(.NODES(NODES)) u_seek (
    .mask  (mask_q),
    .start (ptr_q),
    .idx   (seek_idx),
    .found (seek_found)
  );

  assign rel_ok        = (state == HOLD) && token_release_i[holder_q];
  assign last          = holder_q == IW'(NODES - 1);
  assign token_grant_o = (state == HOLD) ? (NODES'(1) << holder_q) : '0;
  assign busy_o        = state != IDLE;
  assign holder_o      = holder_q;
  assign round_done_o  = state == DONE;
  assign round_count_o = count_q;
  assign stall_o       = stall_q;
  assign overrun_o     = overrun_q;
  assign spurious_o    = spurious_q;

  assign stall_set    = (state == HOLD) && (hold_q >= CW'(HOLD_LIMIT - 1));
  assign overrun_set  = trigger_i && (state != IDLE);
  assign spurious_set = |(token_release_i & ~token_grant_o);

  // state register; reset drops the grant immediately because the grant decodes from state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= next;
  end

  // next-state: the last node finishes the round directly so the pointer never wraps
  always_comb begin
    next = state;
    next = (state == IDLE) ? (trigger_i ? SEEK : IDLE) :
           (state == SEEK) ? (seek_found ? HOLD : DONE) :
           (state == HOLD) ? (rel_ok ? (last ? DONE : SEEK) : HOLD) :
                             IDLE;
  end

  // round datapath: latched mask, search pointer, holder, hold timer, round counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mask_q   <= '0;
      ptr_q    <= '0;
      holder_q <= '0;
      hold_q   <= '0;
      count_q  <= '0;
    end else begin
      if (state == IDLE && trigger_i) begin
        mask_q <= active_mask_i;
        ptr_q  <= '0;
      end
      if (state == SEEK && seek_found) holder_q <= seek_idx;
      if (rel_ok && !last) ptr_q <= holder_q + IW'(1);
      hold_q <= (state == HOLD && !rel_ok) ?
                ((hold_q == CW'(HOLD_LIMIT)) ? hold_q : hold_q + CW'(1)) : '0;
      if (state == DONE) count_q <= count_q + ROUND_WIDTH'(1);
    end
  end

  // sticky error flags; a set event in the same cycle beats clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q    <= 1'b0;
      overrun_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      stall_q    <= stall_set    | (stall_q    & ~clear_i);
      overrun_q  <= overrun_set  | (overrun_q  & ~clear_i);
      spurious_q <= spurious_set | (spurious_q & ~clear_i);
    end
  end

endmodule

// File: tb/tb_nx_token_scheduler.sv
// tb_nx_token_scheduler: randomized rounds checked against a per-cycle timeline model
module tb_nx_token_scheduler;

  logic        clk = 1'b0;
  logic        rst_i, trigger_i, clear_i;
  logic [7:0]  active_mask_i, token_release_i, token_grant_o;
  logic        busy_o, round_done_o, stall_o, overrun_o, spurious_o;
  logic [2:0]  holder_o;
  logic [15:0] round_count_o;
  int total = 0;
  int bad = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  nx_token_scheduler dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .trigger_i       (trigger_i),
    .active_mask_i   (active_mask_i),
    .clear_i         (clear_i),
    .token_grant_o   (token_grant_o),
    .token_release_i (token_release_i),
    .busy_o          (busy_o),
    .holder_o        (holder_o),
    .round_done_o    (round_done_o),
    .round_count_o   (round_count_o),
    .stall_o         (stall_o),
    .overrun_o       (overrun_o),
    .spurious_o      (spurious_o)
  );

  // Expected timeline: SEEK, then per active node its hold cycles followed by a SEEK
  // gap (none after node 7), then DONE, then idle. Nodes release reactively after h[n]
  // granted cycles; optional injection of a trigger and a node-5 release mid-hold.
  task automatic run_round(input logic [7:0] m, input int h[8], input int inj_node, input int inj_cyc);
    logic [7:0] eg[$];
    logic eb[$];
    logic ed[$];
    int cnt[8];
    int g;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    eg.push_back(8'h00); eb.push_back(1'b1); ed.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        for (int k = 0; k < h[i]; k++) begin
          eg.push_back(8'(1 << i)); eb.push_back(1'b1); ed.push_back(1'b0);
        end
        if (i != 7) begin
          eg.push_back(8'h00); eb.push_back(1'b1); ed.push_back(1'b0);
        end
      end
    end
    eg.push_back(8'h00); eb.push_back(1'b1); ed.push_back(1'b1);
    eg.push_back(8'h00); eb.push_back(1'b0); ed.push_back(1'b0);
    @(negedge clk);
    trigger_i = 1'b1;
    active_mask_i = m;
    for (int c = 0; c < eg.size(); c++) begin
      @(negedge clk);
      trigger_i = 1'b0;
      token_release_i = 8'h00;
      active_mask_i = 8'($urandom);
      total++;
      if (token_grant_o !== eg[c]) begin
        bad++;
        $display("FAIL grant mask=%h cycle=%0d got=%h exp=%h", m, c, token_grant_o, eg[c]);
      end
      total++;
      if (busy_o !== eb[c]) begin
        bad++;
        $display("FAIL busy mask=%h cycle=%0d got=%b exp=%b", m, c, busy_o, eb[c]);
      end
      total++;
      if (round_done_o !== ed[c]) begin
        bad++;
        $display("FAIL round_done mask=%h cycle=%0d got=%b exp=%b", m, c, round_done_o, ed[c]);
      end
      total++;
      if ($countones(token_grant_o) > 1) begin
        bad++;
        $display("FAIL onehot cycle=%0d got=%h exp=at_most_one_bit", c, token_grant_o);
      end
      if (eg[c] != 8'h00) begin
        total++;
        if (holder_o !== 3'($clog2(eg[c]))) begin
          bad++;
          $display("FAIL holder cycle=%0d got=%0d exp=%0d", c, holder_o, $clog2(eg[c]));
        end
      end
      if ($countones(token_grant_o) == 1) begin
        g = $clog2(token_grant_o);
        cnt[g]++;
        if (cnt[g] == h[g]) token_release_i = token_grant_o;
        if (g == inj_node && cnt[g] == inj_cyc) begin
          trigger_i = 1'b1;
          token_release_i = token_release_i | 8'h20;
        end
      end
    end
    token_release_i = 8'h00;
    trigger_i = 1'b0;
    exp_count++;
    total++;
    if (round_count_o !== 16'(exp_count)) begin
      bad++;
      $display("FAIL round_count got=%0d exp=%0d", round_count_o, exp_count);
    end
  endtask

  task automatic rand_holds(output int h[8], input int hi);
    for (int i = 0; i < 8; i++) h[i] = $urandom_range(hi, 1);
  endtask

  task automatic pulse_clear;
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (token_grant_o !== 8'h00 || holder_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_grant got=%h/%0d exp=00/0", token_grant_o, holder_o);
    end
    total++;
    if (busy_o !== 1'b0 || round_done_o !== 1'b0 || round_count_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_status got=%b%b/%0d exp=00/0", busy_o, round_done_o, round_count_o);
    end
    total++;
    if ({stall_o, overrun_o, spurious_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b%b%b exp=000", stall_o, overrun_o, spurious_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_round;
    int h[8];
    for (int i = 0; i < 8; i++) h[i] = 2;
    run_round(8'hFF, h, -1, 0);
    total++;
    if ({stall_o, overrun_o, spurious_o} !== 3'b000) begin
      bad++;
      $display("FAIL full_flags got=%b%b%b exp=000", stall_o, overrun_o, spurious_o);
    end
  endtask

  task automatic test_sparse;
    int h[8];
    rand_holds(h, 4);
    run_round(8'h91, h, -1, 0);
  endtask

  task automatic test_empty;
    int h[8];
    rand_holds(h, 4);
    run_round(8'h00, h, -1, 0);
  endtask

  task automatic test_random;
    int h[8];
    for (int r = 0; r < 6; r++) begin
      rand_holds(h, 5);
      run_round(8'($urandom), h, -1, 0);
    end
    total++;
    if ({stall_o, overrun_o, spurious_o} !== 3'b000) begin
      bad++;
      $display("FAIL random_flags got=%b%b%b exp=000", stall_o, overrun_o, spurious_o);
    end
  endtask

  task automatic test_stall;
    bit found = 1'b0;
    bit seen = 1'b0;
    @(negedge clk);
    trigger_i = 1'b1;
    active_mask_i = 8'h08;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      trigger_i = 1'b0;
      if (token_grant_o == 8'h08) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stall_grant_start got=%h exp=08", token_grant_o);
    end
    for (int k = 1; k <= 70; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (token_grant_o !== 8'h08) begin
        bad++;
        $display("FAIL stall_grant k=%0d got=%h exp=08", k, token_grant_o);
      end
      if (k == 63) begin
        total++;
        if (stall_o !== 1'b0) begin
          bad++;
          $display("FAIL stall_early k=%0d got=%b exp=0", k, stall_o);
        end
      end
      if (k == 66) begin
        total++;
        if (stall_o !== 1'b1) begin
          bad++;
          $display("FAIL stall_set k=%0d got=%b exp=1", k, stall_o);
        end
      end
      token_release_i = (k == 70) ? 8'h08 : 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      token_release_i = 8'h00;
      if (round_done_o) seen = 1'b1;
    end
    exp_count++;
    total++;
    if (!seen || round_count_o !== 16'(exp_count)) begin
      bad++;
      $display("FAIL stall_round got=%b/%0d exp=1/%0d", seen, round_count_o, exp_count);
    end
    pulse_clear;
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_clear got=%b exp=0", stall_o);
    end
  endtask

  task automatic test_misbehave;
    int h[8];
    rand_holds(h, 3);
    h[2] = 6;
    total++;
    if ({overrun_o, spurious_o} !== 2'b00) begin
      bad++;
      $display("FAIL misbehave_pre got=%b%b exp=00", overrun_o, spurious_o);
    end
    run_round(8'hFF, h, 2, 2);
    total++;
    if (overrun_o !== 1'b1) begin
      bad++;
      $display("FAIL overrun got=%b exp=1", overrun_o);
    end
    total++;
    if (spurious_o !== 1'b1) begin
      bad++;
      $display("FAIL spurious got=%b exp=1", spurious_o);
    end
    pulse_clear;
    total++;
    if ({overrun_o, spurious_o} !== 2'b00) begin
      bad++;
      $display("FAIL misbehave_clear got=%b%b exp=00", overrun_o, spurious_o);
    end
  endtask

  task automatic test_reset_mid;
    int h[8];
    bit found = 1'b0;
    @(negedge clk);
    trigger_i = 1'b1;
    active_mask_i = 8'hFF;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      trigger_i = 1'b0;
      token_release_i = 8'h00;
      if (token_grant_o == 8'h10) found = 1'b1;
      else if (token_grant_o != 8'h00 && token_grant_o < 8'h10) token_release_i = token_grant_o;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_reach got=%h exp=10", token_grant_o);
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if (token_grant_o !== 8'h00 || holder_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_grant got=%h/%0d exp=00/0", token_grant_o, holder_o);
    end
    total++;
    if (busy_o !== 1'b0 || round_count_o !== 16'd0 || {stall_o, overrun_o, spurious_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_status got=%b/%0d/%b%b%b exp=0/0/000", busy_o, round_count_o, stall_o, overrun_o, spurious_o);
    end
    exp_count = 0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rand_holds(h, 3);
    run_round(8'hFF, h, -1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    trigger_i = 1'b0;
    active_mask_i = 8'h00;
    clear_i = 1'b0;
    token_release_i = 8'h00;
    test_reset;
    test_full_round;
    test_sparse;
    test_empty;
    test_random;
    test_stall;
    test_misbehave;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nx_token_scheduler.md
Name: nx_token_scheduler

Overview:
- Owns the shared outbound channel token for a column of NODES nodes.
- Passes one token in a fixed round-robin order, once per simulation step.
- Drives each node's token_grant_i and consumes each node's token_release_o.
- Sits beside the mesh controller, which starts each step with trigger_i, and reports step completion so the controller knows all emits are done.

Parameters:
- NODES, 8: nodes sharing the token. Minimum 2.
- HOLD_LIMIT, 64: cycles a holder may keep the token before the stall flag sets. Minimum 1.
- ROUND_WIDTH, 16: width of the completed-round counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- trigger_i  in  1  start-round pulse
- active_mask_i  in  NODES  nodes taking part in the round; latched at trigger
- clear_i  in  1  clears sticky flags
- token_grant_o  in/out: out  NODES  one-hot or zero level grant, one bit per node
- token_release_i  in  NODES  per-node release pulse
- busy_o  out  1  round in progress
- holder_o  out  $clog2(NODES)  index of current holder; valid while a grant is asserted
- round_done_o  out  1  single-cycle pulse at end of round
- round_count_o  out  ROUND_WIDTH  completed rounds, wraps
- stall_o  out  1  sticky: a holder reached HOLD_LIMIT
- overrun_o  out  1  sticky: trigger_i arrived while busy
- spurious_o  out  1  sticky: release from a node that was not granted

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Grants drop immediately on assertion of rst_i, mid-round included. There is no resume after reset.
- States: IDLE, SEEK, HOLD, DONE.
- IDLE:
  - On trigger_i, latch active_mask_i into mask_q, set ptr=0, go to SEEK.
  - busy_o rises on the cycle after trigger_i.
- SEEK (1 cycle per step):
  - Find the lowest set bit of mask_q at index >= ptr.
  - If found: holder_q=idx and go to HOLD. token_grant_o[idx] is registered, so it asserts on the next cycle.
  - If none: go to DONE.
  - An empty mask therefore passes IDLE->SEEK->DONE.
- HOLD:
  - token_grant_o = 1<<holder_q and stays high until release.
  - The hold counter increments every cycle in HOLD and saturates at HOLD_LIMIT.
  - On the cycle it equals HOLD_LIMIT, stall_o sets. The token is never revoked.
  - When token_release_i[holder_q]=1: the grant deasserts on the next cycle, ptr=holder_q+1, the hold counter clears, and the state goes to SEEK.
  - If holder_q==NODES-1, go straight to DONE instead. ptr must not wrap.
  - Release asserted in the same cycle the grant first appears is accepted.
  - Gap between consecutive grants: exactly 1 cycle with no grant (the SEEK cycle).
- DONE (1 cycle):
  - round_done_o=1 and round_count_o increments, wrapping modulo 2^ROUND_WIDTH.
  - busy_o drops on the next cycle; go to IDLE.
  - trigger_i in DONE counts as an overrun and is ignored.
- Outside IDLE:
  - trigger_i sets overrun_o and is ignored.
  - active_mask_i changes have no effect until the next trigger.
- Any token_release_i bit that is not the granted bit in HOLD, or any bit outside HOLD, sets spurious_o and is otherwise ignored.
- clear_i clears stall_o, overrun_o and spurious_o. A set event in the same cycle wins over clear.
- At most one grant bit is high in any cycle. The assertion lives in the testbench.

Decomposition:
- Add to NXConstants: the scheduler state enum (token_sched_state_t) and a TOKEN_HOLD_LIMIT default.
- One sub-module, nx_token_seek: combinational find-first-set at or above a start index over NODES bits. Outputs are index and found.
- The FSM, counters and flags stay in nx_token_scheduler.

Test Plan:
- Full round (NODES=8, mask=0xFF, each node releases 2 cycles after its grant):
  - Grants go 0..7 in order, one-hot, with a 1-cycle gap between grants.
  - round_done_o pulses once and round_count_o=1.
- Sparse mask 0x91:
  - Only nodes 0, 4 and 7 are granted, in that order.
  - Node 7 releases, then DONE occurs with no further SEEK.
- Empty mask 0x00, trigger:
  - round_done_o pulses 2 cycles after trigger, with no grants.
  - busy_o is high for exactly 2 cycles.
- Node 3 holds for 70 cycles with HOLD_LIMIT=64:
  - stall_o sets at hold cycle 64 and the grant stays on node 3 until release.
  - clear_i afterwards drops stall_o.
- Misbehaviour during a round:
  - trigger_i mid-round sets overrun_o and does not restart the round.
  - Release from node 5 while node 2 holds sets spurious_o and the grant stays on 2.
- Reset mid-round:
  - rst_i low while node 4 is granted drops the grant asynchronously and returns all outputs to 0.
  - After reset is released, the next trigger restarts the round from node 0.
